// File: rtl/vec_alu_pkg.sv
// Shared opcode values and lane slicing helper for the vector ALU pipeline.
package vec_alu_pkg;

  localparam int OP_ADD   = 1;
  localparam int OP_SUB   = 2;
  localparam int OP_XOR   = 3;
  localparam int OP_AND   = 4;
  localparam int OP_OR    = 5;
  localparam int OP_MOVS  = 6;
  localparam int OP_MOVSR = 7;
  localparam int OP_SHL   = 8;
  localparam int OP_SHR   = 9;
  localparam int OP_ROR   = 10;
  localparam int OP_ROL   = 11;

  // Bit offset of lane 'lane' inside a packed vector of elem_bits-wide lanes.
  function automatic int lane_lsb(input int lane, input int elem_bits);
    return lane * elem_bits;
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One lane of the vector ALU: purely combinational, one element wide.
// Produces the lane result, a zero flag (only for legal opcodes) and the
// signed-overflow flag for ADD/SUB.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int ELEM_BITS = 8,
  parameter int ALUOP     = 4
) (
  input  logic [ALUOP-1:0]     op_i,
  input  logic [ELEM_BITS-1:0] a_i,
  input  logic [ELEM_BITS-1:0] b_i,
  input  logic [ELEM_BITS-1:0] scalar_i,
  output logic [ELEM_BITS-1:0] res_o,
  output logic                 zero_o,
  output logic                 ovf_o
);

  localparam int SHW = $clog2(ELEM_BITS);
  localparam int MSB = ELEM_BITS - 1;

  logic [SHW-1:0]         amt;
  logic                   amt_big;
  logic [2*ELEM_BITS-1:0] dbl;
  logic [2*ELEM_BITS-1:0] rot_r;
  logic [2*ELEM_BITS-1:0] rot_l;
  logic [ELEM_BITS-1:0]   sum;
  logic [ELEM_BITS-1:0]   diff;
  logic                   legal;
  int                     op_n;

  // Lane datapath: pick the result for the opcode, flag overflow and zero.
  always_comb begin
    op_n    = int'(op_i);
    amt     = b_i[SHW-1:0];
    // Any set bit at or above log2(ELEM_BITS) means the shift amount is >= ELEM_BITS.
    amt_big = |b_i[ELEM_BITS-1:SHW];
    dbl     = {a_i, a_i};
    rot_r   = dbl >> amt;
    rot_l   = dbl << amt;
    sum     = a_i + b_i;
    diff    = a_i - b_i;
    res_o   = '0;
    ovf_o   = 1'b0;
    legal   = 1'b1;
    case (op_n)
      OP_ADD: begin
        res_o = sum;
        ovf_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res_o = diff;
        ovf_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_XOR:   res_o = a_i ^ b_i;
      OP_AND:   res_o = a_i & b_i;
      OP_OR:    res_o = a_i | b_i;
      OP_MOVS,
      OP_MOVSR: res_o = scalar_i;
      OP_SHL:   res_o = amt_big ? '0 : (a_i << amt);
      OP_SHR:   res_o = amt_big ? '0 : (a_i >> amt);
      OP_ROR:   res_o = rot_r[ELEM_BITS-1:0];
      OP_ROL:   res_o = rot_l[2*ELEM_BITS-1:ELEM_BITS];
      default:  legal = 1'b0;
    endcase
    zero_o = legal && (res_o == '0);
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage pipelined multi-lane ALU with valid/ready on both sides.
// S1 holds the accepted opcode and operands; S2 holds the computed result
// and flags, which drive the outputs directly.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload until the transfer;
// ready may depend combinationally on the consumer's ready. Here in_ready
// follows out_ready through the S1-advance term, and outputs stay frozen
// while out_valid && !out_ready.
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int ELEM_BITS = 8,
  parameter int LANES     = 4,
  parameter int ALUOP     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALUOP-1:0]           alu_op,
  input  logic [LANES*ELEM_BITS-1:0] vec_a,
  input  logic [LANES*ELEM_BITS-1:0] vec_b,
  input  logic [ELEM_BITS-1:0]       scalar_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ELEM_BITS-1:0] alu_result,
  output logic [LANES-1:0]           zero,
  output logic [LANES-1:0]           overflow,
  output logic                       illegal_op
);

  localparam int VW = LANES * ELEM_BITS;

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d;
  logic [ALUOP-1:0]     s1_op_q;
  logic [VW-1:0]        s1_a_q;
  logic [VW-1:0]        s1_b_q;
  logic [ELEM_BITS-1:0] s1_scalar_q;

  // Stage 2 registers
  logic                 s2_valid_q, s2_valid_d;
  logic [VW-1:0]        result_q;
  logic [LANES-1:0]     zero_q;
  logic [LANES-1:0]     ovf_q;
  logic                 illegal_q;

  logic [ELEM_BITS-1:0] scalar_reg_q, scalar_reg_d;

  logic                 s1_adv;
  logic                 accept;
  int                   s1_op_n;
  logic                 s1_legal;
  logic [ELEM_BITS-1:0] scalar_sel;
  logic [VW-1:0]        lane_res;
  logic [LANES-1:0]     lane_zero;
  logic [LANES-1:0]     lane_ovf;

  // Handshake, opcode decode and next-state terms.
  always_comb begin
    s1_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s1_adv;
    accept     = in_valid && in_ready;
    s1_op_n    = int'(s1_op_q);
    s1_legal   = (s1_op_n >= OP_ADD) && (s1_op_n <= OP_ROL);
    // MOVSR forwards its own scalar; MOVS reads the register as of this edge,
    // which already holds any MOVSR that moved to S2 on an earlier edge.
    scalar_sel = (s1_op_n == OP_MOVSR) ? s1_scalar_q : scalar_reg_q;

    s1_valid_d = s1_valid_q;
    if (accept) s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;

    scalar_reg_d = scalar_reg_q;
    if (s1_adv && s1_valid_q && (s1_op_n == OP_MOVSR)) scalar_reg_d = s1_scalar_q;
  end

  // One combinational lane per element.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int LSB = lane_lsb(g, ELEM_BITS);
    vec_alu_lane #(
      .ELEM_BITS(ELEM_BITS),
      .ALUOP    (ALUOP)
    ) u_lane (
      .op_i    (s1_op_q),
      .a_i     (s1_a_q[LSB +: ELEM_BITS]),
      .b_i     (s1_b_q[LSB +: ELEM_BITS]),
      .scalar_i(scalar_sel),
      .res_o   (lane_res[LSB +: ELEM_BITS]),
      .zero_o  (lane_zero[g]),
      .ovf_o   (lane_ovf[g])
    );
  end

  // S1: capture opcode and operands on an accepted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_scalar_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_op_q     <= alu_op;
        s1_a_q      <= vec_a;
        s1_b_q      <= vec_b;
        s1_scalar_q <= scalar_in;
      end
    end
  end

  // S2: register the lane results and flags when S1 advances with valid data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= '0;
      ovf_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv && s1_valid_q) begin
        result_q  <= lane_res;
        zero_q    <= lane_zero;
        ovf_q     <= lane_ovf;
        illegal_q <= !s1_legal;
      end
    end
  end

  // Scalar register, written by MOVSR as it leaves S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scalar_reg_q <= '0;
    else     scalar_reg_q <= scalar_reg_d;
  end

  assign out_valid  = s2_valid_q;
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;
  assign illegal_op = illegal_q;

endmodule
